// File: rtl/level_state_controller.sv
// Game-flow controller: title, play, death screen, respawn and win sequencing,
// with per-level save points, hazards, exits and the level-2 spine trigger.
`timescale 1ns/1ps
module level_state_controller #(
  parameter int BRICK        = 20,
  parameter int DEATH_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] mario_pos_x,
  input  logic [9:0] mario_pos_y,
  input  logic [9:0] spine_x,
  output logic [1:0] level,
  output logic [1:0] bg_index,
  output logic       spine_trigger,
  output logic       respawn,
  output logic [9:0] respawn_x,
  output logic [9:0] respawn_y,
  output logic       save_reached,
  output logic [7:0] death_count
);

  localparam logic [2:0] S_TITLE   = 3'd0;
  localparam logic [2:0] S_PLAY    = 3'd1;
  localparam logic [2:0] S_DYING   = 3'd2;
  localparam logic [2:0] S_RESPAWN = 3'd3;
  localparam logic [2:0] S_WIN     = 3'd4;

  localparam int CW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_FRAME = CW'(DEATH_FRAMES - 1);

  logic [2:0]    r_state;
  logic          r_lvl2;
  logic [1:0]    r_bg;
  logic          r_save;
  logic [7:0]    r_deaths;
  logic          r_spine_trig;
  logic          r_spine_armed;
  logic [CW-1:0] r_frame_cnt;
  logic [9:0]    r_resp_x;
  logic [9:0]    r_resp_y;

  // 11-bit geometry so right/bottom edges never wrap
  logic [10:0] w_x, w_y, w_xr, w_yb, w_sx;
  logic        w_h1, w_h2, w_fall, w_dead, w_save_hit, w_exit_x, w_spine_zone, w_enter;

  assign w_x  = {1'b0, mario_pos_x};
  assign w_y  = {1'b0, mario_pos_y};
  assign w_xr = w_x + 11'd16;
  assign w_yb = w_y + 11'd24;
  assign w_sx = {1'b0, spine_x};

  assign w_h1 = (w_xr > 11'(21*BRICK)) && (w_x < 11'(22*BRICK)) && (w_yb > 11'(20*BRICK));
  // left edge of the spine window may be below zero; compare with BRICK moved across
  assign w_h2 = (spine_x != 10'd0) && ((w_xr + 11'(BRICK)) > w_sx) && (w_x < w_sx) &&
                (w_yb > 11'(8*BRICK)) && (w_y < 11'(13*BRICK));
  assign w_fall = w_y >= 11'(23*BRICK);
  assign w_dead = w_fall || (r_lvl2 ? w_h2 : w_h1);

  assign w_save_hit = r_lvl2 ?
    ((w_x >= 11'(28*BRICK)) && (w_x < 11'(29*BRICK)) && (w_yb >= 11'(15*BRICK))) :
    ((w_x >= 11'(3*BRICK))  && (w_x < 11'(4*BRICK))  && (w_yb >= 11'(20*BRICK)));
  assign w_exit_x     = w_x >= 11'(31*BRICK - 16);
  assign w_spine_zone = (w_x >= 11'(5*BRICK)) && (w_y < 11'(7*BRICK));
  assign w_enter      = keycode == 8'h28;

  function automatic logic [19:0] f_spawn(input logic lvl2, input logic saved);
    logic [19:0] v;
    if (!lvl2) v = saved ? {10'(3*BRICK), 10'(20*BRICK - 24)} : {10'(BRICK), 10'(16*BRICK)};
    else       v = saved ? {10'(28*BRICK), 10'(15*BRICK - 24)} : {10'(BRICK), 10'(13*BRICK - 24)};
    return v;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_TITLE;
      r_lvl2        <= 1'b0;
      r_bg          <= '0;
      r_save        <= 1'b0;
      r_deaths      <= '0;
      r_spine_trig  <= 1'b0;
      r_spine_armed <= 1'b0;
      r_frame_cnt   <= '0;
      r_resp_x      <= '0;
      r_resp_y      <= '0;
    end else begin
      r_spine_trig <= 1'b0;
      case (r_state)
        S_TITLE: begin
          r_save <= 1'b0;
          if (frame_tick && w_enter) begin
            r_state               <= S_RESPAWN;
            r_lvl2                <= 1'b0;
            {r_resp_x, r_resp_y}  <= f_spawn(1'b0, 1'b0);
          end
        end
        S_RESPAWN: begin
          r_state       <= S_PLAY;
          r_spine_armed <= 1'b1;
        end
        S_PLAY: if (frame_tick) begin
          if (r_lvl2 && r_spine_armed && w_spine_zone) begin
            r_spine_trig  <= 1'b1;
            r_spine_armed <= 1'b0;
          end
          // death outranks exit and save on the same tick
          if (w_dead) begin
            r_state     <= S_DYING;
            r_bg        <= 2'd1;
            r_frame_cnt <= '0;
            if (r_deaths != 8'hFF) r_deaths <= r_deaths + 8'd1;
          end else if (w_exit_x && !r_lvl2) begin
            r_state              <= S_RESPAWN;
            r_lvl2               <= 1'b1;
            r_save               <= 1'b0;
            {r_resp_x, r_resp_y} <= f_spawn(1'b1, 1'b0);
          end else if (w_exit_x && r_lvl2 && (w_y < 11'(10*BRICK))) begin
            r_state <= S_WIN;
            r_bg    <= 2'd1;
            r_save  <= 1'b0;
          end else if (w_save_hit) begin
            r_save <= 1'b1;
          end
        end
        S_DYING: if (frame_tick) begin
          if (r_frame_cnt == LAST_FRAME) begin
            r_frame_cnt          <= '0;
            r_bg                 <= '0;
            r_state              <= S_RESPAWN;
            {r_resp_x, r_resp_y} <= f_spawn(r_lvl2, r_save);
          end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
        S_WIN: if (frame_tick && w_enter) begin
          r_state <= S_TITLE;
          r_bg    <= '0;
        end
        default: r_state <= S_TITLE;
      endcase
    end
  end

  assign level         = (r_state == S_TITLE) ? 2'd0 :
                         (r_state == S_WIN)   ? 2'd3 : {r_lvl2, ~r_lvl2};
  assign bg_index      = r_bg;
  assign spine_trigger = r_spine_trig;
  assign respawn       = r_state == S_RESPAWN;
  assign respawn_x     = r_resp_x;
  assign respawn_y     = r_resp_y;
  assign save_reached  = r_save;
  assign death_count   = r_deaths;

endmodule

// File: tb/tb_level_state_controller.sv
// Bench for level_state_controller: directed scenarios plus randomized play,
// all checked every cycle against a rule-level game model.
`timescale 1ns/1ps
module tb_level_state_controller;

  localparam int B  = 20;
  localparam int DF = 60;

  localparam int M_TITLE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_DYING = 2;
  localparam int M_RESP  = 3;
  localparam int M_WIN   = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = '0;
  logic [9:0] mario_pos_x = '0, mario_pos_y = '0, spine_x = '0;
  logic [1:0] level, bg_index;
  logic       spine_trigger, respawn, save_reached;
  logic [9:0] respawn_x, respawn_y;
  logic [7:0] death_count;

  level_state_controller #(.BRICK(B), .DEATH_FRAMES(DF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .mario_pos_x(mario_pos_x), .mario_pos_y(mario_pos_y), .spine_x(spine_x),
    .level(level), .bg_index(bg_index), .spine_trigger(spine_trigger),
    .respawn(respawn), .respawn_x(respawn_x), .respawn_y(respawn_y),
    .save_reached(save_reached), .death_count(death_count)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // game model
  int m_mode, m_lvl, m_save, m_deaths, m_bg, m_rx, m_ry, m_armed, m_left, m_trig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ov(input int a0, input int a1, input int b0, input int b1);
    return (a0 < b1) && (b0 < a1);
  endfunction

  task automatic model_reset();
    m_mode = M_TITLE; m_lvl = 1; m_save = 0; m_deaths = 0; m_bg = 0;
    m_rx = 0; m_ry = 0; m_armed = 0; m_left = 0; m_trig = 0;
  endtask

  task automatic model_spawn();
    if (m_lvl == 1) begin
      m_rx = m_save ? 3*B  : B;  m_ry = m_save ? 20*B - 24 : 16*B;
    end else begin
      m_rx = m_save ? 28*B : B;  m_ry = m_save ? 15*B - 24 : 13*B - 24;
    end
  endtask

  task automatic model_step(input int tick, input int key, input int x, input int y, input int sx);
    int xr, yb;
    bit dead, saving;
    xr = x + 16; yb = y + 24;
    if (m_lvl == 1) dead = ov(x, xr, 21*B, 22*B) && (yb > 20*B);
    else            dead = (sx != 0) && ov(x, xr, sx - B, sx) && ov(y, yb, 8*B, 13*B);
    dead = dead || (y >= 23*B);
    saving = (m_lvl == 1) ? (x >= 3*B && x < 4*B && yb >= 20*B)
                          : (x >= 28*B && x < 29*B && yb >= 15*B);
    m_trig = 0;
    case (m_mode)
      M_TITLE: begin
        m_save = 0;
        if (tick != 0 && key == 8'h28) begin
          m_lvl = 1; m_save = 0; model_spawn(); m_mode = M_RESP;
        end
      end
      M_RESP: begin m_mode = M_PLAY; m_armed = 1; end
      M_PLAY: if (tick != 0) begin
        if (m_lvl == 2 && m_armed != 0 && x >= 5*B && y < 7*B) begin
          m_trig = 1; m_armed = 0;
        end
        if (dead) begin
          m_mode = M_DYING; m_bg = 1; m_left = DF;
          m_deaths = (m_deaths < 255) ? m_deaths + 1 : 255;
        end else if (m_lvl == 1 && x >= 31*B - 16) begin
          m_lvl = 2; m_save = 0; model_spawn(); m_mode = M_RESP;
        end else if (m_lvl == 2 && x >= 31*B - 16 && y < 10*B) begin
          m_mode = M_WIN; m_bg = 1; m_save = 0;
        end else if (saving) begin
          m_save = 1;
        end
      end
      M_DYING: if (tick != 0) begin
        m_left--;
        if (m_left == 0) begin m_bg = 0; model_spawn(); m_mode = M_RESP; end
      end
      M_WIN: if (tick != 0 && key == 8'h28) begin m_mode = M_TITLE; m_bg = 0; end
      default: ;
    endcase
  endtask

  task automatic check_all();
    int exp_level;
    exp_level = (m_mode == M_TITLE) ? 0 : (m_mode == M_WIN) ? 3 : m_lvl;
    chk("level",      level,         exp_level);
    chk("bg_index",   bg_index,      m_bg);
    chk("save",       save_reached,  m_save);
    chk("deaths",     death_count,   m_deaths);
    chk("respawn",    respawn,       (m_mode == M_RESP) ? 1 : 0);
    chk("spine_trig", spine_trigger, m_trig);
    chk("respawn_x",  respawn_x,     m_rx);
    chk("respawn_y",  respawn_y,     m_ry);
  endtask

  // drive one cycle of inputs, advance model and DUT, then compare
  task automatic apply(input int tick, input int key, input int x, input int y, input int sx);
    frame_tick  = (tick != 0);
    keycode     = 8'(key);
    mario_pos_x = 10'(x);
    mario_pos_y = 10'(y);
    spine_x     = 10'(sx);
    model_step(tick, key, x, y, sx);
    @(posedge Clk); #1;
    check_all();
  endtask

  task automatic reset_now();
    Reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge Clk); #1;
    Reset = 1'b0;
    check_all();
  endtask

  task automatic ticks(input int n, input int x, input int y, input int sx);
    for (int i = 0; i < n; i++) apply(1, 0, x, y, sx);
  endtask

  int xs[16] = '{0, 59, 60, 79, 80, 403, 404, 439, 440, 559, 560, 579, 580, 603, 604, 639};
  int ys[14] = '{0, 119, 120, 139, 140, 199, 200, 275, 276, 376, 377, 459, 460, 470};

  initial begin
    int x, y, sx;
    model_reset();
    @(posedge Clk); #1;
    reset_now();

    // start game
    apply(1, 8'h28, 0, 0, 0);
    chk("start_level", level, 1);
    chk("start_respawn", respawn, 1);
    chk("start_rx", respawn_x, 20);
    chk("start_ry", respawn_y, 320);
    apply(0, 0, 0, 0, 0);
    chk("start_play_pulse_end", respawn, 0);

    // level-1 save, then death on H1
    apply(1, 0, 65, 380, 0);
    chk("l1_save", save_reached, 1);
    apply(1, 0, 425, 390, 0);
    chk("l1_die_deaths", death_count, 1);
    chk("l1_die_bg", bg_index, 1);
    ticks(DF - 1, 65, 380, 0);
    chk("l1_dying_hold", bg_index, 1);
    ticks(1, 65, 380, 0);
    chk("l1_resp_pulse", respawn, 1);
    chk("l1_resp_x", respawn_x, 60);
    chk("l1_resp_y", respawn_y, 376);
    chk("l1_save_kept", save_reached, 1);
    apply(0, 0, 60, 376, 0);

    // exit to level 2, spine trigger fires once
    apply(1, 0, 605, 300, 0);
    chk("l2_level", level, 2);
    chk("l2_save_clr", save_reached, 0);
    chk("l2_rx", respawn_x, 20);
    chk("l2_ry", respawn_y, 236);
    apply(0, 0, 20, 236, 0);
    apply(1, 0, 110, 120, 0);
    chk("spine_pulse", spine_trigger, 1);
    apply(1, 0, 110, 120, 0);
    chk("spine_once", spine_trigger, 0);
    apply(0, 0, 110, 120, 0);

    // moving spine kills; inactive spine does not
    apply(1, 0, 290, 200, 300);
    chk("h2_die", bg_index, 1);
    ticks(DF, 20, 236, 0);
    apply(0, 0, 20, 236, 0);
    apply(1, 0, 290, 200, 0);
    chk("h2_inactive", bg_index, 0);

    // save and fall together: death wins
    apply(1, 0, 565, 470, 0);
    chk("sim_save_fall_bg", bg_index, 1);
    chk("sim_save_fall_save", save_reached, 0);
    ticks(5, 20, 236, 0);
    reset_now();
    chk("mid_dying_reset_level", level, 0);
    chk("mid_dying_reset_deaths", death_count, 0);

    // one death, reach level 2, win, back to title keeping the count
    apply(1, 8'h28, 0, 0, 0);
    apply(0, 0, 20, 320, 0);
    apply(1, 0, 20, 470, 0);
    ticks(DF, 20, 320, 0);
    apply(0, 0, 20, 320, 0);
    apply(1, 0, 605, 300, 0);
    apply(0, 0, 20, 236, 0);
    apply(1, 0, 610, 150, 0);
    chk("win_level", level, 3);
    chk("win_bg", bg_index, 1);
    apply(1, 8'h28, 610, 150, 0);
    chk("title_level", level, 0);
    chk("title_deaths", death_count, 1);

    // repeated falls drive death_count into saturation
    for (int i = 0; i < 17000; i++) apply(1, 8'h28, 20, 470, 0);
    chk("deaths_saturated", death_count, 255);

    // randomized play
    reset_now();
    for (int i = 0; i < 6000; i++) begin
      x = ($urandom % 2 == 0) ? xs[$urandom % 16] : int'($urandom_range(0, 639));
      y = ($urandom % 2 == 0) ? ys[$urandom % 14] : int'($urandom_range(0, 479));
      case ($urandom % 4)
        0, 1: sx = 0;
        2:    sx = x + int'($urandom_range(0, 40));
        default: sx = int'($urandom_range(1, 639));
      endcase
      if ($urandom % 1500 == 0) reset_now();
      else apply(($urandom % 3 != 0) ? 1 : 0,
                 ($urandom % 6 == 0) ? 8'h28 : int'($urandom % 256), x, y, sx);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
